// File: rtl/gray_step_ctrl.sv
// Step controller for a Gray counter datapath: turns debounced button pulses into
// step strobes (manual, timed auto-run, hold) and tracks a binary shadow position.
module gray_step_ctrl #(
    parameter int N      = 4,
    parameter int RATE   = 8,
    parameter int RATE_W = 8,
    parameter int WRAP   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_p,
    input  logic         dn_p,
    input  logic         mode_p,
    output logic         cnt_en,
    output logic         cnt_dir,
    output logic [N-1:0] pos,
    output logic [1:0]   mode
);

    typedef enum logic [1:0] {
        MANUAL  = 2'b00,
        AUTO_UP = 2'b01,
        AUTO_DN = 2'b10,
        HOLD    = 2'b11
    } state_t;

    localparam logic [N-1:0]      POS_MAX    = {N{1'b1}};
    localparam logic [N-1:0]      POS_MIN    = {N{1'b0}};
    localparam logic [N-1:0]      POS_ONE    = N'(1);
    localparam logic [RATE_W-1:0] PRESC_ZERO = {RATE_W{1'b0}};
    localparam logic [RATE_W-1:0] PRESC_ONE  = RATE_W'(1);
    localparam logic [RATE_W-1:0] PRESC_LAST = RATE_W'(RATE - 1);
    localparam logic              WRAP_EN    = (WRAP != 0);

    state_t            state_r;
    logic [RATE_W-1:0] presc_r;
    logic [N-1:0]      pos_r;
    logic              cnt_en_r;
    logic              cnt_dir_r;

    state_t            state_nxt_s;
    logic [RATE_W-1:0] presc_nxt_s;
    logic              step_s;
    logic              step_up_s;
    logic [N-1:0]      pos_nxt_s;
    logic              btn_up_s;
    logic              btn_dn_s;
    logic              tick_s;
    logic              at_max_s;
    logic              at_min_s;

    function automatic state_t mode_after(input state_t s);
        case (s)
            MANUAL:  mode_after = AUTO_UP;
            AUTO_UP: mode_after = AUTO_DN;
            AUTO_DN: mode_after = HOLD;
            HOLD:    mode_after = MANUAL;
            default: mode_after = MANUAL;
        endcase
    endfunction

    assign btn_up_s = up_p & ~dn_p;
    assign btn_dn_s = dn_p & ~up_p;
    assign tick_s   = (presc_r == PRESC_LAST);
    assign at_max_s = (pos_r == POS_MAX);
    assign at_min_s = (pos_r == POS_MIN);

    // Step decision and next mode/prescaler for the coming edge.
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = presc_r;
        step_s      = 1'b0;
        step_up_s   = cnt_dir_r;
        if (mode_p) begin
            state_nxt_s = mode_after(state_r);
            presc_nxt_s = PRESC_ZERO;
        end else begin
            case (state_r)
                MANUAL: begin
                    if (btn_up_s) begin
                        step_s    = WRAP_EN | ~at_max_s;
                        step_up_s = 1'b1;
                    end else if (btn_dn_s) begin
                        step_s    = WRAP_EN | ~at_min_s;
                        step_up_s = 1'b0;
                    end else begin
                        step_s    = 1'b0;
                    end
                end
                AUTO_UP, AUTO_DN: begin
                    if (btn_up_s | btn_dn_s) begin
                        state_nxt_s = btn_up_s ? AUTO_UP : AUTO_DN;
                        presc_nxt_s = PRESC_ZERO;
                    end else if (tick_s) begin
                        presc_nxt_s = PRESC_ZERO;
                        step_s      = 1'b1;
                        // At an end without wrap the run bounces: flip and step back.
                        if (state_r == AUTO_UP) begin
                            if (!WRAP_EN && at_max_s) begin
                                state_nxt_s = AUTO_DN;
                                step_up_s   = 1'b0;
                            end else begin
                                step_up_s   = 1'b1;
                            end
                        end else begin
                            if (!WRAP_EN && at_min_s) begin
                                state_nxt_s = AUTO_UP;
                                step_up_s   = 1'b1;
                            end else begin
                                step_up_s   = 1'b0;
                            end
                        end
                    end else begin
                        presc_nxt_s = presc_r + PRESC_ONE;
                    end
                end
                HOLD: begin
                    presc_nxt_s = presc_r;
                end
                default: begin
                    state_nxt_s = MANUAL;
                    presc_nxt_s = PRESC_ZERO;
                end
            endcase
        end
    end

    // Shadow position follows the step; N-bit arithmetic gives the wrap for free.
    always_comb begin
        if (step_up_s) begin
            pos_nxt_s = pos_r + POS_ONE;
        end else begin
            pos_nxt_s = pos_r - POS_ONE;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= MANUAL;
            presc_r   <= PRESC_ZERO;
            pos_r     <= POS_MIN;
            cnt_en_r  <= 1'b0;
            cnt_dir_r <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            presc_r  <= presc_nxt_s;
            cnt_en_r <= step_s;
            if (step_s) begin
                cnt_dir_r <= step_up_s;
                pos_r     <= pos_nxt_s;
            end else begin
                cnt_dir_r <= cnt_dir_r;
                pos_r     <= pos_r;
            end
        end
    end

    assign cnt_en  = cnt_en_r;
    assign cnt_dir = cnt_dir_r;
    assign pos     = pos_r;
    assign mode    = state_r;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Bench for gray_step_ctrl: saturating and wrapping instances share directed stimulus
// and are checked every cycle against an event-time model plus hand-computed values.
module tb_gray_step_ctrl;

    localparam int N    = 4;
    localparam int RATE = 8;
    localparam int MAXP = (1 << N) - 1;

    logic clk;
    logic rst;
    logic up_p;
    logic dn_p;
    logic mode_p;

    logic         en0, dir0, en1, dir1;
    logic [N-1:0] pos0, pos1;
    logic [1:0]   mode0, mode1;

    gray_step_ctrl #(.N(N), .RATE(RATE), .RATE_W(8), .WRAP(0)) dut (
        .clk(clk), .rst(rst), .up_p(up_p), .dn_p(dn_p), .mode_p(mode_p),
        .cnt_en(en0), .cnt_dir(dir0), .pos(pos0), .mode(mode0)
    );

    gray_step_ctrl #(.N(N), .RATE(RATE), .RATE_W(8), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .up_p(up_p), .dn_p(dn_p), .mode_p(mode_p),
        .cnt_en(en1), .cnt_dir(dir1), .pos(pos1), .mode(mode1)
    );

    logic [7:0] dut_vec [2];
    assign dut_vec[0] = {en0, dir0, pos0, mode0};
    assign dut_vec[1] = {en1, dir1, pos1, mode1};

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    // model: mode index follows 0..3 as the status code; auto steps fall on edges a multiple of RATE after the last clear
    int m_mode [2] = '{0, 0};
    int m_pos [2] = '{0, 0};
    int m_anchor [2] = '{0, 0};
    bit m_en [2] = '{1'b0, 1'b0};
    bit m_dir [2] = '{1'b1, 1'b1};
    int ecnt = 0;
    logic [N-1:0] gray_t [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic take(input int w, input int d);
        m_en[w]  = 1'b1;
        m_dir[w] = (d > 0);
        m_pos[w] = (m_pos[w] + d + MAXP + 1) % (MAXP + 1);
    endtask

    task automatic model_edge(input int w);
        bit wrap;
        int d;
        wrap = (w == 1);
        m_en[w] = 1'b0;
        if (mode_p) begin
            m_mode[w]   = (m_mode[w] + 1) % 4;
            m_anchor[w] = ecnt;
        end else if (m_mode[w] == 0) begin
            if (up_p && !dn_p && (wrap || m_pos[w] < MAXP)) take(w, 1);
            else if (dn_p && !up_p && (wrap || m_pos[w] > 0)) take(w, -1);
        end else if (m_mode[w] == 1 || m_mode[w] == 2) begin
            if (up_p != dn_p) begin
                m_mode[w]   = up_p ? 1 : 2;
                m_anchor[w] = ecnt;
            end else if ((ecnt - m_anchor[w]) % RATE == 0) begin
                d = (m_mode[w] == 1) ? 1 : -1;
                if (!wrap && ((d == 1 && m_pos[w] == MAXP) || (d == -1 && m_pos[w] == 0))) begin
                    d = -d;
                    m_mode[w] = 3 - m_mode[w];
                end
                take(w, d);
            end
        end
    endtask

    // model update on every edge
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                ecnt = 0;
                for (int w = 0; w < 2; w++) begin
                    m_mode[w] = 0; m_pos[w] = 0; m_anchor[w] = 0;
                    m_en[w] = 1'b0; m_dir[w] = 1'b1;
                end
            end else begin
                ecnt++;
                for (int w = 0; w < 2; w++) model_edge(w);
            end
        end
    end

    // per-cycle compare, plus a Gray counter driven by the DUT strobes
    initial begin
        gray_t[0] = '0;
        gray_t[1] = '0;
        forever begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                logic [7:0] e;
                e = {m_en[w], m_dir[w], 4'(m_pos[w]), 2'(m_mode[w])};
                chk(w == 1 ? "outs_wrap" : "outs_sat", int'(dut_vec[w]), int'(e));
                if (rst) begin
                    gray_t[w] = '0;
                end else if (dut_vec[w][7]) begin
                    gray_t[w] = dut_vec[w][6] ? b2g(g2b(gray_t[w]) + 4'd1) : b2g(g2b(gray_t[w]) - 4'd1);
                end
                chk(w == 1 ? "gray_wrap" : "gray_sat", int'(gray_t[w]), int'(b2g(4'(m_pos[w]))));
            end
            if (en0) strobes++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic u, input logic d, input logic m);
        @(negedge clk);
        #1;
        up_p = u; dn_p = d; mode_p = m;
        @(negedge clk);
        #1;
        up_p = 1'b0; dn_p = 1'b0; mode_p = 1'b0;
    endtask

    initial begin
        int s0;
        rst = 1'b1; up_p = 1'b0; dn_p = 1'b0; mode_p = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_mode", mode0, 0);
        chk("rst_pos", pos0, 0);
        chk("rst_en", en0, 0);
        chk("rst_dir", dir0, 1);

        // manual: up x3, down x1, four clocks apart
        s0 = strobes;
        pulse(1'b1, 1'b0, 1'b0); idle(3);
        pulse(1'b1, 1'b0, 1'b0); idle(3);
        pulse(1'b1, 1'b0, 1'b0); idle(3);
        pulse(1'b0, 1'b1, 1'b0);
        chk("man_last_dir", {en0, dir0}, 2'b10);
        idle(3);
        chk("man_strobes", strobes - s0, 4);
        chk("man_pos", pos0, 2);
        chk("man_gray", b2g(pos0), 4'h3);

        // simultaneous presses
        pulse(1'b1, 1'b1, 1'b0);
        chk("both_en", en0, 0);
        chk("both_pos", pos0, 2);
        pulse(1'b1, 1'b0, 1'b1);
        chk("modeup_mode", mode0, 1);
        chk("modeup_en", en0, 0);
        chk("modeup_pos", pos0, 2);

        // run to pos 5 in AUTO_UP, then async reset mid-run
        idle(24);
        chk("run_pos5", pos0, 5);
        chk("run_mode", mode0, 1);
        chk("run_en", en0, 1);
        rst = 1'b1;
        #1;
        chk("arst_mode", mode0, 0);
        chk("arst_pos", pos0, 0);
        chk("arst_en", en0, 0);
        chk("arst_dir", dir0, 1);
        @(negedge clk); #1; up_p = 1'b1;
        @(negedge clk); #1; up_p = 1'b0; rst = 1'b0;
        idle(2);
        chk("lost_pulse_pos", pos0, 0);

        // auto run, then retarget down mid-interval
        pulse(1'b0, 1'b0, 1'b1);
        idle(20);
        chk("auto_pos", pos0, 2);
        pulse(1'b0, 1'b1, 1'b0);
        chk("retarget_mode", mode0, 2);
        chk("retarget_en", en0, 0);
        idle(7);
        chk("dn_early_en", en0, 0);
        chk("dn_early_pos", pos0, 2);
        idle(1);
        chk("dn_step", {en0, dir0, pos0}, {1'b1, 1'b0, 4'd1});

        // hold
        idle(3);
        pulse(1'b0, 1'b0, 1'b1);
        chk("hold_mode", mode0, 3);
        s0 = strobes;
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        idle(50);
        chk("hold_strobes", strobes - s0, 0);
        chk("hold_pos", pos0, 1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("hold_exit_mode", mode0, 0);

        // ends
        pulse(1'b0, 1'b1, 1'b0);
        chk("end_dn_pos", pos0, 0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("sat_low", {en0, pos0}, {1'b0, 4'd0});
        chk("wrap_low", {en1, dir1, pos1}, {1'b1, 1'b0, 4'd15});
        for (int k = 0; k < 15; k++) begin
            pulse(1'b1, 1'b0, 1'b0);
            if (k == 0) chk("wrap_high_up", {en1, pos1}, {1'b1, 4'd0});
            idle(1);
        end
        pulse(1'b1, 1'b0, 1'b0);
        chk("sat_high", {en0, pos0}, {1'b0, 4'd15});
        chk("wrap_to15", pos1, 15);
        pulse(1'b1, 1'b0, 1'b0);
        chk("wrap_15_to_0", {en1, dir1, pos1}, {1'b1, 1'b1, 4'd0});
        chk("sat_stays", pos0, 15);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        idle(8);
        chk("bounce_reach", {en0, mode0, pos0}, {1'b1, 2'b01, 4'd15});
        chk("auto_wrap", {en1, pos1}, {1'b1, 4'd0});
        idle(8);
        chk("bounce", {en0, dir0, mode0, pos0}, {1'b1, 1'b0, 2'b10, 4'd14});
        chk("auto_wrap_next", {mode1, pos1}, {2'b01, 4'd1});
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
